// File: rtl/reg_view_pkg.sv
// rtl/reg_view_pkg.sv - shared types and 7-segment table for the register viewer
package reg_view_pkg;

    typedef enum logic [1:0] {
        S_SEL  = 2'd0,
        S_CAP  = 2'd1,
        S_SHOW = 2'd2
    } state_t;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-low {dp,g,f,e,d,c,b,a}, indexed by nibble value (entry 15 first)
    localparam logic [15:0][7:0] SEG_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational nibble to active-low 7-segment decoder
module hex_to_seg7
    import reg_view_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/reg_view_scan.sv
// rtl/reg_view_scan.sv - CPU register viewer on a multiplexed 8-digit 7-segment display
// Optional leading-zero blanking is enabled by defining REG_VIEW_LZB_EN.
module reg_view_scan
    import reg_view_pkg::*;
#(
    parameter int PRESC = 50000,
    parameter int HOLD  = 256
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        auto_en,
    input  logic [4:0]  sw_sel,
    input  logic        step,
    output logic [4:0]  reg_sel,
    input  logic [31:0] reg_data,
    output logic [7:0]  seg,
    output logic [7:0]  an
);

    localparam int PW = $clog2(PRESC);
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    logic [PW-1:0] pcnt;
    logic          tick;
    logic [2:0]    dig;
    logic [4:0]    target;
    logic [4:0]    last_idx;
    logic [31:0]   shown;
    logic [HW-1:0] hold_cnt;
    state_t        state;
    state_t        state_nxt;

    logic          ld_sel;
    logic          cap;
    logic          tgt_we;
    logic [4:0]    tgt_val;
    logic          hold_inc;

    assign tick = (pcnt == PW'(PRESC - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pcnt <= '0;
            dig  <= '0;
        end else begin
            pcnt <= tick ? '0 : pcnt + PW'(1);
            if (tick) begin
                dig <= dig + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_SEL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_SEL:   state_nxt = S_CAP;
            S_CAP:   state_nxt = S_SHOW;
            S_SHOW:  state_nxt = tgt_we ? S_SEL : S_SHOW;
            default: state_nxt = S_SEL;
        endcase
    end

    // Advance beats refresh, so a step coinciding with the final hold tick moves only once
    always_comb begin
        ld_sel   = 1'b0;
        cap      = 1'b0;
        tgt_we   = 1'b0;
        tgt_val  = reg_sel;
        hold_inc = 1'b0;
        case (state)
            S_SEL: ld_sel = 1'b1;
            S_CAP: cap    = 1'b1;
            S_SHOW: begin
                if (!auto_en) begin
                    if ((sw_sel != reg_sel) || tick) begin
                        tgt_we  = 1'b1;
                        tgt_val = sw_sel;
                    end
                end else if (step || (tick && (hold_cnt == HW'(HOLD - 1)))) begin
                    tgt_we  = 1'b1;
                    tgt_val = reg_sel + 5'd1;
                end else if (tick) begin
                    tgt_we   = 1'b1;
                    hold_inc = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            reg_sel  <= '0;
            target   <= '0;
            last_idx <= '0;
            shown    <= '0;
            hold_cnt <= '0;
        end else begin
            if (ld_sel) begin
                reg_sel <= target;
            end
            if (tgt_we) begin
                target <= tgt_val;
            end
            if (cap) begin
                shown    <= reg_data;
                last_idx <= target;
                if (target != last_idx) begin
                    hold_cnt <= '0;
                end
            end else if (hold_inc) begin
                hold_cnt <= hold_cnt + HW'(1);
            end
        end
    end

    logic [3:0] nibble;
    logic [7:0] seg_hex;
    logic       blank;

    assign nibble = shown[{dig, 2'b00} +: 4];

    hex_to_seg7 u_hex (
        .nibble (nibble),
        .seg    (seg_hex)
    );

`ifdef REG_VIEW_LZB_EN
    logic [2:0] msd;

    always_comb begin
        msd = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (shown[4*i +: 4] != 4'd0) begin
                msd = 3'(i);
            end
        end
    end

    assign blank = (dig > msd);
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            an  <= 8'hFF;
            seg <= SEG_OFF;
        end else begin
            an  <= ~(8'd1 << dig);
            seg <= blank ? SEG_OFF : seg_hex;
        end
    end

endmodule

// File: tb/tb_reg_view_scan.sv
// tb/tb_reg_view_scan.sv - self-checking bench for reg_view_scan (PRESC=4, HOLD=2)
module tb_reg_view_scan;
    import reg_view_pkg::*;

    localparam int PRESC = 4;
    localparam int HOLD  = 2;

    logic        clk = 1'b0;
    logic        rstn;
    logic        auto_en;
    logic [4:0]  sw_sel;
    logic        step;
    logic [4:0]  reg_sel;
    logic [31:0] reg_data;
    logic [7:0]  seg;
    logic [7:0]  an;

    logic [31:0] regs [32];
    assign reg_data = regs[reg_sel];

    reg_view_scan #(.PRESC(PRESC), .HOLD(HOLD)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .auto_en  (auto_en),
        .sw_sel   (sw_sel),
        .step     (step),
        .reg_sel  (reg_sel),
        .reg_data (reg_data),
        .seg      (seg),
        .an       (an)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected segments for digit d of value v, from the display rules
    function automatic logic [7:0] exp_seg(input logic [31:0] v, input int d);
        logic [3:0] n;
        n = 4'((v >> (4 * d)) & 32'hF);
`ifdef REG_VIEW_LZB_EN
        if (d > 0 && (v >> (4 * d)) == 32'd0) return 8'hFF;
`endif
        case (n)
            4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
            4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
            4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
            4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
        endcase
    endfunction

    // Edges since reset release; the scan position is pure arithmetic on this count
    int k;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) k <= 0;
        else       k <= k + 1;
    end

    bit          settled = 1'b0;
    logic [31:0] exp_val = '0;

    always @(negedge clk) begin
        if (rstn) begin
            logic [7:0] exp_an;
            int d;
            d = (k > 0) ? ((k - 1) / PRESC) % 8 : 0;
            exp_an = (k == 0) ? 8'hFF : ~(8'd1 << d);
            check("an_scan", {24'd0, an}, {24'd0, exp_an});
            check("seg_dp", {31'd0, seg[7]}, 32'd1);
            if (settled && k > 0) begin
                check("seg_scan", {24'd0, seg}, {24'd0, exp_seg(exp_val, d)});
            end
        end
    end

    task automatic wait_an(input logic [7:0] t, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (an == t) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic settle(input logic [31:0] v);
        settled = 1'b0;
        repeat (10) @(negedge clk);
        exp_val = v;
        settled = 1'b1;
    endtask

    initial begin
        bit          ok;
        logic [4:0]  prev;
        logic [4:0]  seq_val [3];
        int          seq_cyc [3];
        int          nseq;

        for (int i = 0; i < 32; i++) regs[i] = 32'h0101_0101 * i;
        regs[0]  = 32'hC0DE_0000;
        regs[5]  = 32'h1234_ABCD;
        regs[7]  = 32'h0000_0000;
        regs[10] = 32'h0000_00A0;

        rstn = 1'b0; auto_en = 1'b0; sw_sel = 5'd0; step = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_an", {24'd0, an}, 32'hFF);
        check("rst_seg", {24'd0, seg}, 32'hFF);
        check("rst_reg_sel", {27'd0, reg_sel}, 32'd0);
        rstn = 1'b1;
        @(posedge clk); #1;
        check("rel_reg_sel", {27'd0, reg_sel}, 32'd0);
        check("rel_an_first", {24'd0, an}, 32'hFE);
        @(posedge clk); #1;
        check("rel_shown_r0", dut.shown, 32'hC0DE_0000);

        // Manual selection of r5
        @(negedge clk); sw_sel = 5'd5;
        ok = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (dut.shown == 32'h1234_ABCD) begin ok = 1'b1; break; end
        end
        check("man_shown_r5", dut.shown, 32'h1234_ABCD);
        settle(32'h1234_ABCD);
        wait_an(8'hFE, ok); check("r5_wait_d0", {31'd0, ok}, 32'd1);
        check("r5_seg_d0", {24'd0, seg}, 32'hA1);
        wait_an(8'h7F, ok); check("r5_wait_d7", {31'd0, ok}, 32'd1);
        check("r5_seg_d7", {24'd0, seg}, 32'hF9);

        // Live refresh of r7 while shown
        sw_sel = 5'd7;
        settle(32'h0);
        repeat (12) @(negedge clk);
        settled = 1'b0;
        regs[7] = 32'hFFFF_0000;
        ok = 1'b0;
        for (int i = 0; i < PRESC + 3; i++) begin
            @(posedge clk); #1;
            if (dut.shown == 32'hFFFF_0000) begin ok = 1'b1; break; end
        end
        check("r7_live_update", dut.shown, 32'hFFFF_0000);
        @(negedge clk);
        settle(32'hFFFF_0000);
        repeat (34) @(negedge clk);

        // Leading-digit behaviour on 0x000000A0
        sw_sel = 5'd10;
        settle(32'h0000_00A0);
        wait_an(8'hFE, ok); check("a0_seg_d0", {24'd0, seg}, 32'hC0);
        wait_an(8'hFD, ok); check("a0_seg_d1", {24'd0, seg}, 32'h88);
`ifdef REG_VIEW_LZB_EN
        wait_an(8'hFB, ok); check("a0_seg_d2", {24'd0, seg}, 32'hFF);
        wait_an(8'h7F, ok); check("a0_seg_d7", {24'd0, seg}, 32'hFF);
`else
        wait_an(8'hFB, ok); check("a0_seg_d2", {24'd0, seg}, 32'hC0);
        wait_an(8'h7F, ok); check("a0_seg_d7", {24'd0, seg}, 32'hC0);
`endif

        // Auto stepping from r30 through the wrap
        sw_sel = 5'd30;
        settle(32'h0101_0101 * 30);
        settled = 1'b0;
        auto_en = 1'b1;
        prev = 5'd30;
        nseq = 0;
        for (int c = 0; c < 80 && nseq < 3; c++) begin
            @(negedge clk);
            if (reg_sel != prev) begin
                seq_val[nseq] = reg_sel;
                seq_cyc[nseq] = c;
                nseq++;
                prev = reg_sel;
            end
        end
        check("auto_seq_count", nseq, 3);
        if (nseq == 3) begin
            check("auto_seq_0", {27'd0, seq_val[0]}, 32'd31);
            check("auto_seq_1", {27'd0, seq_val[1]}, 32'd0);
            check("auto_seq_2", {27'd0, seq_val[2]}, 32'd1);
            check("auto_dwell_31", {31'd0, (seq_cyc[1] - seq_cyc[0]) inside {[5:11]}}, 32'd1);
            check("auto_dwell_0", {31'd0, (seq_cyc[2] - seq_cyc[1]) inside {[5:11]}}, 32'd1);
        end

        // Step coincident with the final hold tick advances once
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dut.state == S_SHOW && dut.tick && dut.hold_cnt == 1'b1) begin ok = 1'b1; break; end
        end
        check("coinc_found", {31'd0, ok}, 32'd1);
        prev = reg_sel;
        step = 1'b1;
        @(negedge clk); step = 1'b0;
        repeat (5) @(negedge clk);
        check("coinc_one_adv", {27'd0, reg_sel}, {27'd0, 5'(prev + 5'd1)});

        // Step alone in auto mode
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dut.state == S_SHOW && !dut.tick) begin ok = 1'b1; break; end
        end
        prev = reg_sel;
        step = 1'b1;
        @(negedge clk); step = 1'b0;
        repeat (2) @(negedge clk);
        check("step_adv", {27'd0, reg_sel}, {27'd0, 5'(prev + 5'd1)});

        // Step ignored in manual mode
        auto_en = 1'b0;
        sw_sel = 5'd9;
        repeat (10) @(negedge clk);
        step = 1'b1;
        @(negedge clk); step = 1'b0;
        repeat (6) @(negedge clk);
        check("man_step_ign", {27'd0, reg_sel}, 32'd9);

        // Asynchronous reset mid-scan
        #3 rstn = 1'b0;
        #1;
        check("mid_rst_an", {24'd0, an}, 32'hFF);
        check("mid_rst_seg", {24'd0, seg}, 32'hFF);
        check("mid_rst_reg_sel", {27'd0, reg_sel}, 32'd0);
        check("mid_rst_shown", dut.shown, 32'd0);
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;
        check("mid_rel_reg_sel", {27'd0, reg_sel}, 32'd0);
        repeat (4) @(negedge clk);
        check("mid_rel_reg_sel9", {27'd0, reg_sel}, 32'd9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_view_scan.md
# reg_view_scan

Register-file viewer for the pipelined CPU top level. It drives the CPU's `reg_sel` debug read port and captures the returned `reg_data`. It shows the 32-bit value as eight hex digits on a time-multiplexed, active-low 7-segment display. Two modes are supported: automatic stepping through r0..r31, or manual selection from switches.

## Interface
Parameters:
- `PRESC`, 50000: clk cycles per refresh tick (digit-scan period); minimum 2.
- `HOLD`, 256: refresh ticks each register stays on screen in auto mode; minimum 1.

Ports:
- `clk`  in  1  system clock, single clock domain.
- `rstn`  in  1  asynchronous, active-low reset.
- `auto_en`  in  1  1 = auto-step r0..r31, 0 = manual.
- `sw_sel`  in  5  register index in manual mode.
- `step`  in  1  one-cycle pulse; in auto mode forces an immediate advance.
- `reg_sel`  out  5  registered read index to the CPU debug port.
- `reg_data`  in  32  combinational read data for `reg_sel`.
- `seg`  out  8  active-low segments {dp,g,f,e,d,c,b,a}; dp is always 1.
- `an`  out  8  active-low digit enables; bit 0 is the rightmost nibble.

## Operation
- **Prescaler:** `pcnt` counts 0..PRESC-1 and wraps. `tick` is high for one cycle when `pcnt`==PRESC-1.
- **Digit counter:** `dig` (3 bits) increments on `tick` and wraps 7->0.
  - `an` <= ~(1<<dig).
  - `seg` <= hex pattern of `shown[4*dig+:4]`.
  - Both are registered.
- **FSM states:** S_SEL, S_CAP, S_SHOW.
  - **S_SEL:** `reg_sel` <= `target`; next state S_CAP.
  - **S_CAP:** `shown` <= `reg_data`. If `target` differs from the last displayed index, clear `hold_cnt`. Next state S_SHOW.
  - **S_SHOW, manual:** go to S_SEL with `target`=`sw_sel` if `sw_sel`!=`reg_sel` or `tick`. This keeps the displayed value live.
  - **S_SHOW, auto, advance:** if `step`, or `tick` with `hold_cnt`==HOLD-1, then `target`=`reg_sel`+1 (5-bit wrap, 31->0) and go to S_SEL.
  - **S_SHOW, auto, refresh:** otherwise on `tick`, `hold_cnt`++ and go to S_SEL with `target`=`reg_sel`.
- **Simultaneous `step` and `tick`:** exactly one advance.
- **`step` in manual mode:** ignored.
- **`auto_en` toggles:** take effect at the next S_SHOW decision. Manual to auto starts counting from the current `reg_sel`.
- **r0:** displays whatever `reg_data` returns; no special-casing.

## Timing
- **Reset values:** `reg_sel`=0, `target`=0, `shown`=0, `pcnt`=0, `dig`=0, `hold_cnt`=0, state S_SEL, `an`=8'hFF, `seg`=8'hFF.
- **After reset release:**
  - `reg_sel`=0 in cycle 1.
  - `shown`=r0 value in cycle 2.
  - First digit enabled one cycle after the first `pcnt` update (`an`=8'hFE).
- **Manual `sw_sel` change:** S_SHOW detects it (cycle 0). `reg_sel` is updated at cycle 1 and `shown` at cycle 2. The segments reflect the new value on the next `an` update.
- **`reg_data` sampling:** exactly one cycle after `reg_sel` is registered, assuming a combinational register-file read.
- **Auto dwell:** HOLD×PRESC cycles per register, ±3 cycles of FSM overhead.
- **Async reset mid-scan:** all state returns to reset values immediately. There is no partial capture.

## Configuration
- **`REG_VIEW_LZB_EN` defined:** leading-zero blanking. Digits above the most significant non-zero nibble drive `seg`=8'hFF while `an` still scans. Digit 0 is always lit, so a value of 0 shows a single "0".
- **`REG_VIEW_LZB_EN` undefined:** all eight digits are always shown, including leading zeros.

## Structure
- **Shared package `reg_view_pkg`:**
  - State enum (S_SEL, S_CAP, S_SHOW).
  - 16-entry active-low 7-segment constant table.
  - `SEG_OFF`=8'hFF.
- **Sub-module `hex_to_seg7`:** combinational 4-bit to 8-bit decoder using the package table. The top level instantiates it once on the selected nibble.

## Test plan
All scenarios use PRESC=4 and HOLD=2 for simulation.
1. Assert `rstn`=0 mid-run → `an`=8'hFF, `seg`=8'hFF, `reg_sel`=0 in the same delta. Release `rstn` → `reg_sel`=0 within 1 clock.
2. Manual mode, `sw_sel`=5, model returns r5=32'h1234ABCD → `shown`=32'h1234ABCD within 3 cycles. On `an`=8'hFE, `seg`=8'hA1 ("d"). On `an`=8'h7F, `seg`=8'hF9 ("1").
3. Auto mode from r30 → `reg_sel` goes 30→31→0, dwelling 8±3 cycles each. It wraps to 0 and never shows 32.
4. Auto mode, `step` pulse coincident with `tick` and `hold_cnt`==HOLD-1 → `reg_sel` advances by exactly 1. `step` in manual mode → `reg_sel` unchanged.
5. Manual mode, model changes r7 from 0 to 32'hFFFF0000 while displayed → `shown` updates within PRESC+3 cycles.
6. With `REG_VIEW_LZB_EN`, value 32'h0000_00A0 → digits 7..2 show `seg`=8'hFF; digit 1 shows "A" (8'h88); digit 0 shows "0" (8'hC0).
